// File: rtl/sipo_rx_pkg.sv
//==============================================================================
// Module      : sipo_rx_pkg
// Description : State encoding and sizing helper shared by the sipo_rx slice.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sipo_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_rx_if.sv
//==============================================================================
// Module      : sipo_rx_if
// Description : Serial input, sample strobe and parallel valid/ready bundle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface sipo_rx_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic             bit_en_i;
  logic             sd_i;
  logic             ready_i;
  logic [WIDTH-1:0] q_o;
  logic             valid_o;
  logic             busy_o;
  logic             ovf_o;
  logic             perr_o;

  modport master (
    output start_i, bit_en_i, sd_i, ready_i,
    input  q_o, valid_o, busy_o, ovf_o, perr_o
  );

  modport slave (
    input  start_i, bit_en_i, sd_i, ready_i,
    output q_o, valid_o, busy_o, ovf_o, perr_o
  );
endinterface

`default_nettype wire

// File: rtl/sipo_shift.sv
//==============================================================================
// Module      : sipo_shift
// Description : WIDTH-bit shift-left register, enable and synchronous clear.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             clr_i,
  input  wire logic             en_i,
  input  wire logic             d_i,
  output logic      [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_sh;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sh <= '0;
    end else if (clr_i) begin
      r_sh <= '0;
    end else if (en_i) begin
      r_sh <= {r_sh[WIDTH-2:0], d_i};
    end
  end

  assign q_o = r_sh;

endmodule

`default_nettype wire

// File: rtl/sipo_rx.sv
//==============================================================================
// Module      : sipo_rx
// Description : MSB-first serial-in parallel-out receiver with valid/ready
//               output. Define SIPO_RX_PARITY_EN for a trailing even-parity bit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  sipo_rx_if.slave  bus
);

  localparam int c_cnt_w = clog2(WIDTH + 2);
`ifdef SIPO_RX_PARITY_EN
  localparam int c_frame_bits = WIDTH + 1;
`else
  localparam int c_frame_bits = WIDTH;
`endif
  localparam logic [c_cnt_w-1:0] c_last_idx  = c_cnt_w'(c_frame_bits - 1);
  localparam logic [c_cnt_w-1:0] c_data_bits = c_cnt_w'(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   w_sh;
  logic [WIDTH-1:0]   w_word;
  logic               r_ovf;
  logic               w_frame_start;
  logic               w_set_ovf;
  logic               w_strobe;
  logic               w_last;
  logic               w_shift_en;

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_set_ovf     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt   = ST_SHIFT;
          w_frame_start = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.ready_i) begin
          w_state_nxt   = bus.start_i ? ST_SHIFT : ST_IDLE;
          w_frame_start = bus.start_i;
        end else if (bus.start_i) begin
          w_set_ovf = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_strobe   = (r_state == ST_SHIFT) && bus.bit_en_i;
  assign w_last     = w_strobe && (r_cnt == c_last_idx);
  // The parity strobe (count == WIDTH) never enters the data register.
  assign w_shift_en = w_strobe && (r_cnt < c_data_bits);

  sipo_shift #(.WIDTH(WIDTH)) u_shift (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_frame_start),
    .en_i  (w_shift_en),
    .d_i   (bus.sd_i),
    .q_o   (w_sh)
  );

`ifdef SIPO_RX_PARITY_EN
  logic r_perr;
  assign w_word = w_sh;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perr <= 1'b0;
    end else if (w_last) begin
      r_perr <= (^w_sh) ^ bus.sd_i;
    end
  end

  assign bus.perr_o = r_perr;
`else
  // Final data bit is still on sd_i when the word is captured.
  assign w_word     = WIDTH'({w_sh, bus.sd_i});
  assign bus.perr_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_frame_start) begin
        r_cnt <= '0;
      end else if (w_strobe) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_q <= w_word;
      end
      if (w_set_ovf) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.q_o     = r_q;
  assign bus.valid_o = (r_state == ST_HOLD);
  assign bus.busy_o  = (r_state == ST_SHIFT);
  assign bus.ovf_o   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sipo_rx.sv
//==============================================================================
// Module      : tb_sipo_rx
// Description : Randomized self-checking bench for sipo_rx against a bit-list
//               reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sipo_rx;

  localparam int WIDTH = 8;
`ifdef SIPO_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  typedef bit bitq_t[$];

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  sipo_rx_if #(.WIDTH(WIDTH)) bus ();

  sipo_rx #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame as transmitted: WIDTH data bits MSB first, then the parity bit if enabled.
  function automatic bitq_t make_bits(input logic [WIDTH-1:0] data, input bit p);
    bitq_t q;
    for (int i = WIDTH - 1; i >= 0; i--) q.push_back(data[i]);
    if (PAR_BITS == 1) q.push_back(p);
    return q;
  endfunction

  function automatic logic [31:0] model_word(input bitq_t bits);
    logic [31:0] w;
    w = 0;
    for (int i = 0; i < WIDTH; i++) w = w * 2 + 32'(bits[i]);
    return w;
  endfunction

  function automatic logic [31:0] model_perr(input bitq_t bits);
    int ones;
    ones = 0;
    if (PAR_BITS == 0) return 0;
    for (int i = 0; i < bits.size(); i++) ones += int'(bits[i]);
    return 32'(ones % 2);
  endfunction

  // Assumes the DUT is already in SHIFT; leaves it in HOLD.
  task automatic send_bits(input bitq_t bits, input int gap);
    for (int i = 0; i < bits.size(); i++) begin
      for (int g = 1; g < gap; g++) begin
        bus.bit_en_i = 1'b0;
        bus.sd_i     = 1'($urandom_range(0, 1));
        bus.start_i  = 1'($urandom_range(0, 1));
        check_eq("busy_gap", 32'(bus.busy_o), 32'd1);
        check_eq("valid_gap", 32'(bus.valid_o), 32'd0);
        tick();
      end
      bus.bit_en_i = 1'b1;
      bus.sd_i     = bits[i];
      bus.start_i  = 1'b0;
      check_eq("busy_strobe", 32'(bus.busy_o), 32'd1);
      check_eq("valid_strobe", 32'(bus.valid_o), 32'd0);
      tick();
    end
    bus.bit_en_i = 1'b0;
    bus.sd_i     = 1'b0;
    check_eq("valid_done", 32'(bus.valid_o), 32'd1);
    check_eq("busy_done", 32'(bus.busy_o), 32'd0);
    check_eq("q_done", 32'(bus.q_o), model_word(bits));
    check_eq("perr_done", 32'(bus.perr_o), model_perr(bits));
  endtask

  task automatic hold_check(input int n, input bitq_t bits);
    bus.ready_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.bit_en_i = 1'($urandom_range(0, 1));
      bus.sd_i     = 1'($urandom_range(0, 1));
      tick();
      check_eq("hold_valid", 32'(bus.valid_o), 32'd1);
      check_eq("hold_q", 32'(bus.q_o), model_word(bits));
      check_eq("hold_perr", 32'(bus.perr_o), model_perr(bits));
    end
    bus.bit_en_i = 1'b0;
  endtask

  task automatic accept();
    bus.ready_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    bus.ready_i = 1'b0;
    check_eq("acc_valid", 32'(bus.valid_o), 32'd0);
    check_eq("acc_busy", 32'(bus.busy_o), 32'd0);
  endtask

  task automatic start_frame();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check_eq("start_busy", 32'(bus.busy_o), 32'd1);
  endtask

  initial begin
    bitq_t bits;
    bit    in_shift;
    logic [WIDTH-1:0] data;

    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.bit_en_i = 1'b0;
    bus.sd_i     = 1'b0;
    bus.ready_i  = 1'b0;
    tick();
    tick();
    check_eq("rst_q", 32'(bus.q_o), 32'd0);
    check_eq("rst_valid", 32'(bus.valid_o), 32'd0);
    check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
    check_eq("rst_ovf", 32'(bus.ovf_o), 32'd0);
    rst = 1'b0;
    tick();

    // Strobes ignored in IDLE.
    bus.bit_en_i = 1'b1;
    bus.sd_i     = 1'b1;
    tick();
    tick();
    bus.bit_en_i = 1'b0;
    check_eq("idle_busy", 32'(bus.busy_o), 32'd0);
    check_eq("idle_valid", 32'(bus.valid_o), 32'd0);

    // Basic frame, strobe every third cycle, then backpressure.
    bits = make_bits(8'hA5, 1'b0);
    start_frame();
    send_bits(bits, 3);
    check_eq("basic_a5", 32'(bus.q_o), 32'hA5);
    hold_check(6, bits);
    accept();

    // Random frames with random spacing, hold times and back-to-back starts.
    in_shift = 1'b0;
    for (int f = 0; f < 24; f++) begin
      data = WIDTH'($urandom);
      bits = make_bits(data, 1'($urandom_range(0, 1)));
      if (!in_shift) start_frame();
      send_bits(bits, int'($urandom_range(1, 3)));
      hold_check(int'($urandom_range(0, 3)), bits);
      check_eq("rand_ovf", 32'(bus.ovf_o), 32'd0);
      if ($urandom_range(0, 1) == 1) begin
        bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        bus.start_i = 1'b0;
        check_eq("b2b_rand_busy", 32'(bus.busy_o), 32'd1);
        in_shift = 1'b1;
      end else begin
        accept();
        in_shift = 1'b0;
      end
    end
    if (in_shift) begin
      send_bits(make_bits(8'h00, 1'b0), 1);
      accept();
    end

    // Overrun: start while held without ready is dropped and sets the flag.
    bits = make_bits(8'hA5, 1'b0);
    start_frame();
    send_bits(bits, 2);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check_eq("ovf_set", 32'(bus.ovf_o), 32'd1);
    check_eq("ovf_busy", 32'(bus.busy_o), 32'd0);
    hold_check(3, bits);
    check_eq("ovf_sticky", 32'(bus.ovf_o), 32'd1);

    // Back-to-back accept of A5 and start of 3C in one cycle.
    bus.ready_i = 1'b1;
    bus.start_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    bus.start_i = 1'b0;
    check_eq("b2b_busy", 32'(bus.busy_o), 32'd1);
    check_eq("b2b_valid", 32'(bus.valid_o), 32'd0);
    bits = make_bits(8'h3C, 1'b0);
    send_bits(bits, 1);
    check_eq("b2b_3c", 32'(bus.q_o), 32'h3C);
    accept();
    check_eq("ovf_after_acc", 32'(bus.ovf_o), 32'd1);

    // Asynchronous reset mid-frame, observed before the next clock edge.
    bits = make_bits(8'hFF, 1'b0);
    start_frame();
    for (int i = 0; i < 3; i++) begin
      bus.bit_en_i = 1'b1;
      bus.sd_i     = 1'b1;
      tick();
    end
    bus.bit_en_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_q", 32'(bus.q_o), 32'd0);
    check_eq("arst_valid", 32'(bus.valid_o), 32'd0);
    check_eq("arst_busy", 32'(bus.busy_o), 32'd0);
    check_eq("arst_ovf", 32'(bus.ovf_o), 32'd0);
    check_eq("arst_perr", 32'(bus.perr_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // A5 with parity bit 1 then 0 after reset.
    bits = make_bits(8'hA5, 1'b1);
    start_frame();
    send_bits(bits, 2);
    check_eq("par1_q", 32'(bus.q_o), 32'hA5);
    accept();
    bits = make_bits(8'hA5, 1'b0);
    start_frame();
    send_bits(bits, 1);
    check_eq("par0_q", 32'(bus.q_o), 32'hA5);
    accept();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
